// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the pipeline MEM stage and the debug/loader port.
// Grant and stall are combinational from state; debug read data is registered, one cycle after the grant.
module dmem_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int LOCK_MAX   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_rd,
    input  logic                  cpu_wr,
    input  logic [DM_ADDRESS-1:0] cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    input  logic [2:0]            cpu_func3,
    output logic                  cpu_stall,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic                  dbg_lock,
    input  logic [DM_ADDRESS-1:0] dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    output logic                  dbg_gnt,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic                  dbg_rvalid,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_func3,
    input  logic [DATA_W-1:0]     mem_rdata
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int LW = $clog2(LOCK_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [LW-1:0] LOCK_LIM   = LW'(LOCK_MAX);
    localparam logic [LW-1:0] LOCK_ONE   = LW'(1);

    typedef enum logic [1:0] {
        ST_CPU,
        ST_LOCK,
        ST_COOL
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [LW-1:0]     lock_q, lock_d, lock_inc;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;
    logic              cpu_req;
    logic              dbg_win;
    logic              dbg_gnt_w;

    assign cpu_req = cpu_rd | cpu_wr;

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        lock_d   = lock_q;
        dbg_win  = 1'b0;
        lock_inc = lock_q + (dbg_req ? LOCK_ONE : '0);
        case (state_q)
            ST_CPU: begin
                if (dbg_req && (!cpu_req || starve_q == STARVE_LIM)) begin
                    dbg_win  = 1'b1;
                    starve_d = '0;
                    if (dbg_lock) begin
                        state_d = (LOCK_MAX == 1) ? ST_COOL : ST_LOCK;
                        lock_d  = LOCK_ONE;
                    end
                end else if (dbg_req) begin
                    // only reached below the limit, so the increment saturates by itself
                    starve_d = starve_q + SW'(1);
                end else begin
                    starve_d = '0;
                end
            end
            ST_LOCK: begin
                dbg_win  = dbg_req;
                starve_d = '0;
                lock_d   = lock_inc;
                if (!dbg_lock || lock_inc == LOCK_LIM) begin
                    state_d = ST_COOL;
                    lock_d  = '0;
                end
            end
            ST_COOL: begin
                state_d  = ST_CPU;
                starve_d = '0;
            end
            default: begin
                state_d  = ST_CPU;
                starve_d = '0;
                lock_d   = '0;
            end
        endcase
    end

    assign dbg_gnt_w  = dbg_win & ~reset;
    assign dbg_gnt    = dbg_gnt_w;
    assign cpu_stall  = dbg_gnt_w & cpu_req;
    assign mem_rd     = dbg_gnt_w ? ~dbg_we : (cpu_rd & ~reset);
    assign mem_wr     = dbg_gnt_w ? dbg_we  : (cpu_wr & ~reset);
    assign mem_addr   = dbg_gnt_w ? dbg_addr  : cpu_addr;
    assign mem_wdata  = dbg_gnt_w ? dbg_wdata : cpu_wdata;
    assign mem_func3  = dbg_gnt_w ? 3'b010    : cpu_func3;
    assign dbg_rdata  = rdata_q;
    assign dbg_rvalid = rvalid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_CPU;
            starve_q <= '0;
            lock_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            lock_q   <= lock_d;
            rvalid_q <= dbg_gnt_w & ~dbg_we;
            if (dbg_gnt_w && !dbg_we) begin
                rdata_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a rule-level model.
module tb_dmem_arbiter;
    localparam int AW   = 9;
    localparam int DW   = 32;
    localparam int SMAX = 4;
    localparam int LMAX = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_rd, cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [2:0]    cpu_func3;
    logic          cpu_stall;
    logic          dbg_req, dbg_we, dbg_lock;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_rvalid;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_func3;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] phys_mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem  [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(
        .DM_ADDRESS(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .LOCK_MAX(LMAX)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_func3(cpu_func3), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_func3(mem_func3), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] seed_word(int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    assign mem_rdata = phys_mem[mem_addr];

    initial begin
        for (int i = 0; i < (1<<AW); i++) phys_mem[i] = seed_word(i);
        forever begin
            @(posedge clk);
            if (mem_wr) phys_mem[mem_addr] <= mem_wdata;
        end
    end

    // Reference model: debug wait count, burst length, cool-down flag
    int            m_wait, m_burst_n;
    bit            m_burst, m_cool;
    bit            e_gnt, e_stall, e_rd, e_wr, e_rvalid;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;
    logic [2:0]    e_f3;

    function automatic void model_eval();
        bit creq;
        creq = cpu_rd | cpu_wr;
        if (reset || m_cool) e_gnt = 1'b0;
        else if (m_burst)    e_gnt = dbg_req;
        else                 e_gnt = dbg_req && (!creq || m_wait >= SMAX);
        e_stall = e_gnt && creq;
        if (e_gnt) begin
            e_rd = !dbg_we; e_wr = dbg_we; e_addr = dbg_addr; e_wdata = dbg_wdata; e_f3 = 3'b010;
        end else begin
            e_rd = !reset && cpu_rd; e_wr = !reset && cpu_wr;
            e_addr = cpu_addr; e_wdata = cpu_wdata; e_f3 = cpu_func3;
        end
    endfunction

    function automatic void model_commit();
        if (reset) begin
            m_wait = 0; m_burst = 0; m_burst_n = 0; m_cool = 0; e_rvalid = 0; e_rdata = '0;
            return;
        end
        e_rvalid = e_gnt && !dbg_we;
        if (e_rvalid) e_rdata = ref_mem[dbg_addr];
        if (e_wr) ref_mem[e_addr] = e_wdata;
        if (m_cool) begin
            m_cool = 0; m_wait = 0;
        end else if (m_burst) begin
            m_wait = 0;
            if (e_gnt) m_burst_n++;
            if (!dbg_lock || m_burst_n >= LMAX) begin m_burst = 0; m_cool = 1; end
        end else if (e_gnt) begin
            m_wait = 0;
            if (dbg_lock) begin
                m_burst_n = 1;
                if (LMAX == 1) m_cool = 1; else m_burst = 1;
            end
        end else if (dbg_req) begin
            m_wait = (m_wait < SMAX) ? m_wait + 1 : SMAX;
        end else begin
            m_wait = 0;
        end
    endfunction

    task automatic idle();
        cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0; cpu_func3 = 3'b010;
        dbg_req = 0; dbg_we = 0; dbg_lock = 0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    task automatic settle();
        model_eval();
        #1;
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_commit();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle(); reset = 1; cpu_rd = 1; dbg_req = 1; dbg_lock = 1;
            settle();
            total++; if (dbg_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%0b want=0", dbg_gnt); end
            total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b want=0", cpu_stall); end
            total++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin bad++; $display("FAIL rst_mem got=%0b%0b want=00", mem_rd, mem_wr); end
            finish_cycle();
        end
        @(negedge clk);
        idle(); reset = 0;
        settle();
        total++; if (dbg_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%0b want=0", dbg_rvalid); end
        total++; if (dbg_rdata !== '0) begin bad++; $display("FAIL rst_rdata got=%0h want=0", dbg_rdata); end
        finish_cycle();
    endtask

    task automatic test_cpu_only();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            idle(); cpu_rd = 1; cpu_addr = 9'h010;
            settle();
            total++; if (mem_rd !== 1'b1) begin bad++; $display("FAIL cpu_rd cyc%0d got=%0b want=1", i, mem_rd); end
            total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL cpu_stall cyc%0d got=%0b want=0", i, cpu_stall); end
            total++; if (dbg_gnt !== 1'b0) begin bad++; $display("FAIL cpu_gnt cyc%0d got=%0b want=0", i, dbg_gnt); end
            total++; if (mem_addr !== 9'h010) begin bad++; $display("FAIL cpu_addr cyc%0d got=%0h want=010", i, mem_addr); end
            finish_cycle();
        end
    endtask

    task automatic test_dbg_write_read();
        @(negedge clk);
        idle(); dbg_req = 1; dbg_we = 1; dbg_addr = 9'h020; dbg_wdata = 32'hDEADBEEF;
        settle();
        total++; if (dbg_gnt !== 1'b1) begin bad++; $display("FAIL dw_gnt got=%0b want=1", dbg_gnt); end
        total++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0) begin bad++; $display("FAIL dw_wr got=%0b%0b want=01", mem_rd, mem_wr); end
        total++; if (mem_func3 !== 3'b010) begin bad++; $display("FAIL dw_func3 got=%0b want=010", mem_func3); end
        total++; if (mem_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL dw_wdata got=%0h want=deadbeef", mem_wdata); end
        finish_cycle();
        @(negedge clk);
        idle(); dbg_req = 1; dbg_we = 0; dbg_addr = 9'h020;
        settle();
        total++; if (dbg_gnt !== 1'b1 || mem_rd !== 1'b1) begin bad++; $display("FAIL dr_gnt got=%0b%0b want=11", dbg_gnt, mem_rd); end
        finish_cycle();
        @(negedge clk);
        idle();
        settle();
        total++; if (dbg_rvalid !== 1'b1) begin bad++; $display("FAIL dr_rvalid got=%0b want=1", dbg_rvalid); end
        total++; if (dbg_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL dr_rdata got=%0h want=deadbeef", dbg_rdata); end
        finish_cycle();
        @(negedge clk);
        settle();
        total++; if (dbg_rvalid !== 1'b0) begin bad++; $display("FAIL dr_pulse got=%0b want=0", dbg_rvalid); end
        finish_cycle();
    endtask

    task automatic test_starve();
        logic exp;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            idle(); cpu_rd = 1; cpu_addr = 9'h010;
            dbg_req = (i < 6); dbg_we = 1; dbg_addr = 9'h060; dbg_wdata = 32'h12345678;
            settle();
            exp = (i == 5);
            total++; if (dbg_gnt !== exp) begin bad++; $display("FAIL st_gnt cyc%0d got=%0b want=%0b", i, dbg_gnt, exp); end
            total++; if (cpu_stall !== exp) begin bad++; $display("FAIL st_stall cyc%0d got=%0b want=%0b", i, cpu_stall, exp); end
            total++; if (mem_wr !== exp || mem_rd !== !exp) begin bad++; $display("FAIL st_mem cyc%0d got=%0b%0b want=%0b%0b", i, mem_rd, mem_wr, !exp, exp); end
            finish_cycle();
        end
    endtask

    task automatic test_lock_burst();
        logic g, v;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            idle(); cpu_rd = 1; cpu_addr = 9'h010;
            dbg_req = 1; dbg_we = 0; dbg_lock = 1; dbg_addr = 9'h060;
            settle();
            g = (i >= 5 && i <= 12);
            v = (i >= 6 && i <= 13);
            total++; if (dbg_gnt !== g) begin bad++; $display("FAIL lk_gnt cyc%0d got=%0b want=%0b", i, dbg_gnt, g); end
            total++; if (cpu_stall !== g) begin bad++; $display("FAIL lk_stall cyc%0d got=%0b want=%0b", i, cpu_stall, g); end
            total++; if (mem_addr !== (g ? 9'h060 : 9'h010)) begin bad++; $display("FAIL lk_addr cyc%0d got=%0h want=%0h", i, mem_addr, g ? 9'h060 : 9'h010); end
            total++; if (dbg_rvalid !== v) begin bad++; $display("FAIL lk_rvalid cyc%0d got=%0b want=%0b", i, dbg_rvalid, v); end
            if (v) begin
                total++; if (dbg_rdata !== 32'h12345678) begin bad++; $display("FAIL lk_rdata cyc%0d got=%0h want=12345678", i, dbg_rdata); end
            end
            finish_cycle();
        end
    endtask

    task automatic test_early_release();
        logic [5:0] g_tab, s_tab, c_tab, l_tab;
        g_tab = 6'b100111; s_tab = 6'b000110; c_tab = 6'b011110; l_tab = 6'b000011;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            idle(); cpu_rd = c_tab[i]; cpu_addr = 9'h010;
            dbg_req = 1; dbg_we = 0; dbg_lock = l_tab[i]; dbg_addr = 9'h060;
            settle();
            total++; if (dbg_gnt !== g_tab[i]) begin bad++; $display("FAIL er_gnt cyc%0d got=%0b want=%0b", i + 1, dbg_gnt, g_tab[i]); end
            total++; if (cpu_stall !== s_tab[i]) begin bad++; $display("FAIL er_stall cyc%0d got=%0b want=%0b", i + 1, cpu_stall, s_tab[i]); end
            finish_cycle();
        end
    endtask

    task automatic test_reset_mid_lock();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            idle(); reset = (i == 3); cpu_rd = (i >= 2); cpu_addr = 9'h010;
            dbg_req = 1; dbg_we = 0; dbg_lock = 1; dbg_addr = 9'h060;
            settle();
            if (i <= 2) begin
                total++; if (dbg_gnt !== 1'b1) begin bad++; $display("FAIL rl_gnt cyc%0d got=%0b want=1", i, dbg_gnt); end
            end else if (i == 3) begin
                total++; if (dbg_gnt !== 1'b0 || mem_rd !== 1'b0) begin bad++; $display("FAIL rl_rst got=%0b%0b want=00", dbg_gnt, mem_rd); end
            end else begin
                total++; if (dbg_rvalid !== 1'b0) begin bad++; $display("FAIL rl_rvalid got=%0b want=0", dbg_rvalid); end
                total++; if (dbg_gnt !== 1'b0 || mem_addr !== 9'h010) begin bad++; $display("FAIL rl_cpu got=%0b/%0h want=0/010", dbg_gnt, mem_addr); end
            end
            finish_cycle();
        end
        @(negedge clk);
        idle(); reset = 0;
        settle();
        finish_cycle();
    endtask

    task automatic test_random();
        bit pend;
        int r;
        pend = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 149) == 0);
            r = $urandom_range(0, 3);
            cpu_rd = (r == 1 || r == 3); cpu_wr = (r == 2);
            cpu_addr = AW'($urandom); cpu_wdata = $urandom; cpu_func3 = 3'($urandom);
            if (!pend && $urandom_range(0, 2) == 0) begin
                pend = 1; dbg_we = 1'($urandom); dbg_addr = AW'($urandom_range(0, 15) * 4);
                dbg_wdata = $urandom;
                dbg_lock = m_burst ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
            end else if (!pend) begin
                dbg_lock = m_burst && ($urandom_range(0, 7) != 0);
            end
            dbg_req = pend;
            settle();
            total++; if (dbg_gnt !== e_gnt) begin bad++; $display("FAIL rnd_gnt n=%0d got=%0b want=%0b", n, dbg_gnt, e_gnt); end
            total++; if (cpu_stall !== e_stall) begin bad++; $display("FAIL rnd_stall n=%0d got=%0b want=%0b", n, cpu_stall, e_stall); end
            total++; if (mem_rd !== e_rd || mem_wr !== e_wr) begin bad++; $display("FAIL rnd_rw n=%0d got=%0b%0b want=%0b%0b", n, mem_rd, mem_wr, e_rd, e_wr); end
            total++; if (mem_addr !== e_addr) begin bad++; $display("FAIL rnd_addr n=%0d got=%0h want=%0h", n, mem_addr, e_addr); end
            total++; if (mem_wdata !== e_wdata) begin bad++; $display("FAIL rnd_wdata n=%0d got=%0h want=%0h", n, mem_wdata, e_wdata); end
            total++; if (mem_func3 !== e_f3) begin bad++; $display("FAIL rnd_func3 n=%0d got=%0b want=%0b", n, mem_func3, e_f3); end
            total++; if (dbg_rvalid !== e_rvalid) begin bad++; $display("FAIL rnd_rvalid n=%0d got=%0b want=%0b", n, dbg_rvalid, e_rvalid); end
            total++; if (dbg_rdata !== e_rdata) begin bad++; $display("FAIL rnd_rdata n=%0d got=%0h want=%0h", n, dbg_rdata, e_rdata); end
            if (e_gnt) pend = 0;
            finish_cycle();
        end
    endtask

    initial begin
        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = seed_word(i);
        idle();
        reset = 1;
        test_reset();
        test_cpu_only();
        test_dbg_write_read();
        test_starve();
        test_lock_burst();
        test_early_release();
        test_reset_mid_lock();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
